// File: rtl/toy_fetch_unit_pkg.sv
// Shared defaults and FSM state encoding for the TOY instruction fetch unit.
package toy_fetch_unit_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/toy_fetch_wdog.sv
// Clear/enable cycle counter that flags expiry on its LIMIT-th enabled cycle.
// Only compiled when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module toy_fetch_wdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Expiry is combinational so the FSM can leave on the very cycle the limit is reached.
  assign expired = en && (count == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/toy_fetch_unit.sv
// TOY CPU instruction fetch: req/ack memory read into IR, PC advance and jump loads.
// Define FETCH_TIMEOUT_EN to abort fetches that wait TIMEOUT_CYC cycles without mem_ack.
module toy_fetch_unit
  import toy_fetch_unit_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RESET_PC    = 0,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_go,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err
);

  fetch_state_t state, state_next;

  logic              capture;
  logic              timeout_hit;
  logic              expired;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_pc;
  logic              apply_pend;
  logic              load_now;
  logic [ADDR_W-1:0] load_val;

  assign mem_req  = (state == S_REQ) || (state == S_WAIT);
  assign mem_addr = pc_out;
  assign ir_valid = (state == S_DONE);
  assign busy     = (state != S_IDLE);

`ifdef FETCH_TIMEOUT_EN
  toy_fetch_wdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!mem_req),
    .en      (mem_req),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) fetch_err <= 1'b0;
    else       fetch_err <= timeout_hit;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign expired   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next  = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      S_IDLE: if (fetch_go) state_next = S_REQ;
      S_REQ, S_WAIT: begin
        if (mem_ack) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end else if (expired) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // A load requested on the exit cycle itself is the latest one, so it beats the stored value.
  assign apply_pend = (state == S_DONE) || timeout_hit;
  assign load_now   = pc_load || pend_valid;
  assign load_val   = pc_load ? pc_load_val : pend_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out     <= ADDR_W'(RESET_PC);
      ir_out     <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else begin
      if (state == S_IDLE && pc_load) pc_out <= pc_load_val;

      if (capture) begin
        ir_out <= mem_rdata;
        pc_out <= pc_out + ADDR_W'(1);
      end

      if (apply_pend && load_now) pc_out <= load_val;

      if (apply_pend) begin
        pend_valid <= 1'b0;
      end else if (state != S_IDLE && pc_load) begin
        pend_valid <= 1'b1;
        pend_pc    <= pc_load_val;
      end
    end
  end

endmodule

// File: tb/tb_toy_fetch_unit.sv
// Self-checking bench for toy_fetch_unit: directed scenarios plus randomized fetch transactions
// checked against a transaction-level PC/IR model. Honors FETCH_TIMEOUT_EN when defined.
module tb_toy_fetch_unit;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_go;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir_out;
  logic [ADDR_W-1:0] pc_out;
  logic              ir_valid;
  logic              busy;
  logic              fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] model_pc;
  logic [DATA_W-1:0] model_ir;

  toy_fetch_unit #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RESET_PC    (0),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_go    (fetch_go),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir_out      (ir_out),
    .pc_out      (pc_out),
    .ir_valid    (ir_valid),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    fetch_go    = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
  endtask

  // One complete fetch. Inputs change just after each falling edge; outputs are checked there too.
  task automatic do_fetch(input int waits, input logic [DATA_W-1:0] data,
                          input bit go_load, input logic [ADDR_W-1:0] go_val,
                          input int mid_at, input logic [ADDR_W-1:0] mid_val,
                          input bit done_load, input logic [ADDR_W-1:0] done_val);
    bit                pend;
    logic [ADDR_W-1:0] pend_val;
    logic [ADDR_W-1:0] inc_pc;
    pend     = 1'b0;
    pend_val = '0;
    check("idle_busy", busy, 0);
    fetch_go    = 1'b1;
    pc_load     = go_load;
    pc_load_val = go_val;
    mem_ack     = 1'($urandom_range(0, 1));
    mem_rdata   = DATA_W'($urandom);
    if (go_load) model_pc = go_val;
    @(negedge clk);
    for (int k = 0; k <= waits; k++) begin
      check("req_mem_req", mem_req, 1);
      check("req_addr", mem_addr, model_pc);
      check("req_busy", busy, 1);
      check("req_ir_valid", ir_valid, 0);
      check("req_fetch_err", fetch_err, 0);
      fetch_go    = 1'($urandom_range(0, 1));
      mem_ack     = (k == waits);
      mem_rdata   = (k == waits) ? data : DATA_W'($urandom);
      pc_load     = (k == mid_at);
      pc_load_val = mid_val;
      if (k == mid_at) begin
        pend     = 1'b1;
        pend_val = mid_val;
      end
      @(negedge clk);
    end
    inc_pc = model_pc + 12'd1;
    check("done_ir_valid", ir_valid, 1);
    check("done_ir", ir_out, data);
    check("done_pc", pc_out, inc_pc);
    check("done_mem_req", mem_req, 0);
    fetch_go    = 1'($urandom_range(0, 1));
    mem_ack     = 1'($urandom_range(0, 1));
    mem_rdata   = DATA_W'($urandom);
    pc_load     = done_load;
    pc_load_val = done_val;
    if (done_load) begin
      pend     = 1'b1;
      pend_val = done_val;
    end
    @(negedge clk);
    idle_inputs();
    model_pc = pend ? pend_val : inc_pc;
    model_ir = data;
    check("post_pc", pc_out, model_pc);
    check("post_ir", ir_out, model_ir);
    check("post_ir_valid", ir_valid, 0);
    check("post_busy", busy, 0);
    check("post_mem_req", mem_req, 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    model_pc = '0;
    model_ir = '0;
    check("rst_pc", pc_out, 0);
    check("rst_ir", ir_out, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_fetch_err", fetch_err, 0);

    do_fetch(0, 16'hA123, 0, '0, -1, '0, 0, '0);
    check("t1_pc", pc_out, 12'h001);
    do_fetch(3, 16'h1111, 1, 12'hFFF, -1, '0, 0, '0);
    check("t2_wrap", pc_out, 12'h000);
    do_fetch(2, 16'h2222, 0, '0, 1, 12'h040, 0, '0);
    check("t3_pc", pc_out, 12'h040);
    do_fetch(0, 16'h3333, 1, 12'h080, -1, '0, 0, '0);
    check("t4_pc", pc_out, 12'h081);
    // Ack arriving on the last cycle the timeout would allow still completes the fetch.
    do_fetch(TIMEOUT_CYC - 1, 16'h4444, 0, '0, -1, '0, 0, '0);

    // Stray ack while idle must not touch IR or PC.
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    @(negedge clk);
    idle_inputs();
    check("idle_ack_ir", ir_out, model_ir);
    check("idle_ack_pc", pc_out, model_pc);
    check("idle_ack_busy", busy, 0);

    for (int i = 0; i < 40; i++) begin
      int w;
      w = $urandom_range(0, 6);
      do_fetch(w, DATA_W'($urandom), 1'($urandom_range(0, 1)), ADDR_W'($urandom),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, w)) : -1, ADDR_W'($urandom),
               ($urandom_range(0, 3) == 0), ADDR_W'($urandom));
    end

`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      n = 0;
      fetch_go = 1'b1;
      @(negedge clk);
      fetch_go = 1'b0;
      while (mem_req && n < 40) begin
        check("to_addr", mem_addr, model_pc);
        pc_load     = (n == 3);
        pc_load_val = 12'h123;
        n++;
        @(negedge clk);
      end
      pc_load = 1'b0;
      check("to_req_cycles", n, TIMEOUT_CYC);
      check("to_fetch_err", fetch_err, 1);
      check("to_busy", busy, 0);
      check("to_ir", ir_out, model_ir);
      check("to_pc", pc_out, 12'h123);
      model_pc = 12'h123;
      @(negedge clk);
      check("to_err_pulse", fetch_err, 0);
    end
`else
    do_fetch(TIMEOUT_CYC + 5, 16'h5555, 0, '0, -1, '0, 0, '0);
`endif
    do_fetch(1, 16'h5A5A, 0, '0, -1, '0, 0, '0);

    // Reset while waiting abandons the fetch; a late ack is ignored.
    fetch_go = 1'b1;
    @(negedge clk);
    fetch_go = 1'b0;
    @(negedge clk);
    check("t5_in_wait", mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_mem_req", mem_req, 0);
    check("t5_busy", busy, 0);
    check("t5_pc", pc_out, 0);
    check("t5_ir", ir_out, 0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    @(negedge clk);
    idle_inputs();
    check("t5_late_ir", ir_out, 0);
    check("t5_late_valid", ir_valid, 0);
    check("t5_late_busy", busy, 0);
    model_pc = '0;
    model_ir = '0;

    do_fetch(2, 16'hC0DE, 0, '0, -1, '0, 0, '0);
    check("final_pc", pc_out, 12'h001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
